serial_sequence_generator_fsm: RTL and testbench

Transmit-side companion to the serial sequence detectors. It accepts a WIDTH-bit pattern through a start/ready handshake and shifts it out MSB first, one bit per clock, on a serial line `a` qualified by `a_valid`. The pattern can be repeated a programmable number of times with a fixed idle gap between copies. It drives detector FSMs in loopback benches and produces framed serial test streams.

---
 rtl/serial_sequence_generator_fsm.sv | 111 +++++++++++
 tb/tb_serial_sequence_generator_fsm.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sequence_generator_fsm.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB first,
// optionally repeated with a fixed idle gap between copies.
module serial_sequence_generator_fsm #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeats,
    input  logic             abort,
    output logic             ready,
    output logic             a,
    output logic             a_valid,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] pat;
    logic [BW-1:0]    bcnt;
    logic [CNT_W-1:0] ccnt;
    logic [GW-1:0]    gcnt;

    assign ready = (state == S_IDLE);

    // sr holds the bits still to be sent; a carries the bit bcnt points at
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sr      <= '0;
            pat     <= '0;
            bcnt    <= '0;
            ccnt    <= '0;
            gcnt    <= '0;
            a       <= 1'b0;
            a_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        pat     <= pattern;
                        sr      <= pattern << 1;
                        ccnt    <= repeats;
                        bcnt    <= '0;
                        a       <= pattern[WIDTH-1];
                        a_valid <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        a       <= 1'b0;
                        a_valid <= 1'b0;
                        state   <= S_IDLE;
                    end else if (bcnt != BLAST) begin
                        a    <= sr[WIDTH-1];
                        sr   <= sr << 1;
                        bcnt <= bcnt + 1'b1;
                    end else if (ccnt == '0) begin
                        a       <= 1'b0;
                        a_valid <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end else if (GAP == 0) begin
                        ccnt <= ccnt - 1'b1;
                        a    <= pat[WIDTH-1];
                        sr   <= pat << 1;
                        bcnt <= '0;
                    end else begin
                        ccnt    <= ccnt - 1'b1;
                        gcnt    <= '0;
                        a       <= 1'b0;
                        a_valid <= 1'b0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (gcnt == GLAST) begin
                        a       <= pat[WIDTH-1];
                        a_valid <= 1'b1;
                        sr      <= pat << 1;
                        bcnt    <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sequence_generator_fsm.sv
// Bench for serial_sequence_generator_fsm: cycle-by-cycle expectations
// are queued when a start is driven and popped as the DUT runs.
module tb_serial_sequence_generator_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0, abort = 1'b0;
    logic [5:0] pattern = '0;
    logic [3:0] repeats = '0;
    logic       ready, a, a_valid, done;

    logic       start4 = 1'b0, abort4 = 1'b0;
    logic [3:0] pattern4 = '0;
    logic [3:0] repeats4 = '0;
    logic       ready4, a4, a_valid4, done4;

    int checks = 0;
    int failures = 0;

    // entries are {a_valid, a, done, ready} for one cycle
    logic [3:0] q[$];

    serial_sequence_generator_fsm #(.WIDTH(6), .CNT_W(4), .GAP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .repeats(repeats), .abort(abort), .ready(ready), .a(a),
        .a_valid(a_valid), .done(done)
    );

    serial_sequence_generator_fsm #(.WIDTH(4), .CNT_W(4), .GAP(0)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .pattern(pattern4),
        .repeats(repeats4), .abort(abort4), .ready(ready4), .a(a4),
        .a_valid(a_valid4), .done(done4)
    );

    task automatic push_xfer(input logic [31:0] p, input int w,
                             input int rep, input int gap);
        for (int c = 0; c <= rep; c++) begin
            for (int i = w - 1; i >= 0; i--)
                q.push_back({1'b1, p[i], 2'b00});
            if (c < rep)
                for (int g = 0; g < gap; g++) q.push_back(4'b0000);
        end
        q.push_back(4'b0011);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        #12;
        got = {a_valid, a, done, ready};
        checks++;
        if (got !== 4'b0001) begin
            failures++;
            $display("FAIL reset6 got=%b exp=0001", got);
        end
        got = {a_valid4, a4, done4, ready4};
        checks++;
        if (got !== 4'b0001) begin
            failures++;
            $display("FAIL reset4 got=%b exp=0001", got);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {a_valid, a, done, ready};
            checks++;
            if (got !== 4'b0001) begin
                failures++;
                $display("FAIL idle_after_reset got=%b exp=0001", got);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] e, got;
        int n = 0;
        // start with abort in IDLE must still be accepted
        pattern = 6'b110011;
        repeats = 4'd0;
        start = 1'b1;
        abort = 1'b1;
        push_xfer(32'(pattern), 6, 0, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        pattern = 6'b000000;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            got = {a_valid, a, done, ready};
            n++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL single cyc=k+%0d got=%b exp=%b", n, got, e);
            end
        end
        @(negedge clk);
        got = {a_valid, a, done, ready};
        checks++;
        if (got !== 4'b0001) begin
            failures++;
            $display("FAIL single_post got=%b exp=0001", got);
        end
    endtask

    task automatic test_repeats_gap();
        logic [3:0] e, got;
        int n = 0;
        pattern = 6'b110011;
        repeats = 4'd2;
        start = 1'b1;
        push_xfer(32'(pattern), 6, 2, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        pattern = 6'b010101;
        repeats = 4'd9;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            got = {a_valid, a, done, ready};
            n++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL repeats cyc=k+%0d got=%b exp=%b", n, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e, got, hist;
        int n = 0, nb = 0, since = 0;
        int det[$];
        hist = '0;
        pattern4 = 4'b1010;
        repeats4 = 4'd1;
        start4 = 1'b1;
        push_xfer(32'(pattern4), 4, 1, 0);
        @(posedge clk);
        #1;
        start4 = 1'b0;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            got = {a_valid4, a4, done4, ready4};
            n++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL b2b cyc=k+%0d got=%b exp=%b", n, got, e);
            end
            // non-overlapping 1010 detector on the loopback stream
            if (a_valid4) begin
                nb++;
                since++;
                hist = {hist[2:0], a4};
                if (since >= 4 && hist == 4'b1010) begin
                    det.push_back(nb);
                    since = 0;
                end
            end
        end
        checks++;
        if (det.size() != 2) begin
            failures++;
            $display("FAIL b2b_det_count got=%0d exp=2", det.size());
        end else begin
            checks++;
            if (det[0] != 4 || det[1] != 8) begin
                failures++;
                $display("FAIL b2b_det_pos got=%0d,%0d exp=4,8",
                         det[0], det[1]);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] e, got;
        int n = 0;
        pattern = 6'b110011;
        repeats = 4'd0;
        start = 1'b1;
        q.push_back(4'b1100);
        q.push_back(4'b1100);
        q.push_back(4'b1000);
        q.push_back(4'b0001);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = q.pop_front();
            got = {a_valid, a, done, ready};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL abort cyc=k+%0d got=%b exp=%b", i + 1, got, e);
            end
            if (i == 2) abort = 1'b1;
        end
        abort = 1'b0;
        pattern = 6'b101101;
        repeats = 4'd0;
        start = 1'b1;
        push_xfer(32'(pattern), 6, 0, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            got = {a_valid, a, done, ready};
            n++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL abort_restart cyc=k+%0d got=%b exp=%b",
                         n + 4, got, e);
            end
        end
    endtask

    task automatic test_busy();
        logic [3:0] e, got;
        int acc, n = 0;
        pattern = 6'($urandom);
        repeats = 4'($urandom_range(0, 1));
        start = 1'b1;
        push_xfer(32'(pattern), 6, int'(repeats), 2);
        acc = 1;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            got = {a_valid, a, done, ready};
            n++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", n, got, e);
            end
            pattern = 6'($urandom);
            repeats = 4'($urandom_range(0, 1));
            if (e[0]) begin
                if (acc < 3) begin
                    push_xfer(32'(pattern), 6, int'(repeats), 2);
                    acc++;
                end else begin
                    start = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e, got;
        int n = 0;
        pattern = 6'b101011;
        repeats = 4'd3;
        start = 1'b1;
        push_xfer(32'(pattern), 6, 3, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = q.pop_front();
            got = {a_valid, a, done, ready};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL rstmid_pre cyc=k+%0d got=%b exp=%b",
                         i + 1, got, e);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        got = {a_valid, a, done, ready};
        checks++;
        if (got !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=0001", got);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        pattern = 6'b011101;
        repeats = 4'd1;
        start = 1'b1;
        push_xfer(32'(pattern), 6, 1, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            got = {a_valid, a, done, ready};
            n++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL rstmid_post cyc=k+%0d got=%b exp=%b", n, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeats_gap();
        test_back_to_back();
        test_abort();
        test_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
